instr_fetch: RTL
================

Name: instr_fetch

Overview:
- Fetch stage of the Single-CPU datapath. Holds the PC and issues word fetches to instruction memory over a req/ready handshake.
- Presents the fetched instruction, with op/funct and register fields split out, to the control unit for one execute cycle.
- Computes the next PC from the control unit's PCWre, PCSrc and jump outputs and the sign-extended immediate.
- Adds a fetch watchdog and a halt state.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded at reset; bits [1:0] are forced to 0.
- MAX_WAIT, 16, maximum cycles spent in WAIT before fetch_err; 0 disables the watchdog.
- CNT_W, 8, width of the watchdog counter; must satisfy MAX_WAIT < 2^CNT_W.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- PCWre  in  1  from control; 1 = advance PC, 0 = halt instruction
- PCSrc  in  1  from control; 1 = take branch
- jump  in  1  from control; 1 = take jump
- imm_ext  in  32  sign/zero-extended 16-bit immediate from the extender
- imem_req  out  1  fetch request
- imem_addr  out  32  byte address of the fetch, word aligned
- imem_ready  in  1  memory has data on imem_rdata this cycle
- imem_rdata  in  32  instruction word
- instr  out  32  latched instruction register
- instr_valid  out  1  execute cycle strobe
- op  out  6  instr[31:26]
- funct  out  6  instr[5:0]
- rs, rt, rd  out  5 each  instr[25:21], [20:16], [15:11]
- pc  out  32  address of the current instruction
- pc_plus4  out  32  pc + 4
- halted  out  1  core stopped by a halt instruction
- fetch_err  out  1  watchdog expired; sticky until reset

Behaviour:
- Reset (asynchronous, rst_n low):
  - State goes to REQ; pc = RESET_PC & ~3.
  - instr = 0 (so op = 0, funct = 0).
  - instr_valid, halted, fetch_err, imem_req all drive 0 while rst_n is low.
  - Watchdog counter = 0.
  - Reset asserted mid-WAIT drops imem_req immediately; any imem_ready that follows is ignored.
- FSM states are REQ, WAIT, EXEC, HALT.
- REQ (first cycle after reset release, and after each EXEC that advances):
  - imem_req = 1, imem_addr = pc.
  - imem_ready = 1 in this cycle: latch instr <= imem_rdata, go to EXEC.
  - Otherwise go to WAIT and clear the counter.
- WAIT:
  - imem_req stays 1 and imem_addr stays stable until imem_ready.
  - On imem_ready: latch instr, go to EXEC.
  - Otherwise the counter increments.
  - If MAX_WAIT != 0 and the counter reaches MAX_WAIT with no ready: set fetch_err = 1, go to HALT.
- EXEC (exactly 1 cycle):
  - instr_valid = 1, imem_req = 0.
  - Control decodes combinationally from op/funct and the fed-back zero flag.
  - At the clock edge, if PCWre = 1: pc <= next_pc, go to REQ.
  - If PCWre = 0: pc holds, halted <= 1, go to HALT.
- HALT: absorbing until reset.
  - imem_req = 0 and instr_valid = 0.
  - instr and pc hold their values.
- next_pc priority (all arithmetic modulo 2^32, wrap silently):
  - jump = 1: {pc_plus4[31:28], instr[25:0], 2'b00}.
  - else PCSrc = 1: pc_plus4 + (imm_ext << 2).
  - else: pc_plus4.
  - jump and PCSrc both 1: jump wins.
- Boundary and width rules:
  - pc = 32'hFFFF_FFFC sequential: next pc = 0.
  - imem_ready outside REQ/WAIT is ignored.
  - imem_addr[1:0] is always 00.
  - Field outputs are combinational slices of instr, not separately registered.
- Latency: minimum 2 cycles per instruction (REQ with same-cycle ready, then EXEC).

Decomposition:
- Shared package cpu_pkg holds:
  - FSM state encodings (2-bit): REQ, WAIT, EXEC, HALT.
  - Instruction field bit positions (OP_HI/LO, RS/RT/RD, FUNCT, JADDR).
  - RESET_PC default.
- One sub-module, next_pc_calc: combinational next-PC mux and adders. It is reused later by a pipelined fetch.

Test Plan:
- Reset release, RESET_PC = 0, memory ready in the same cycle, word 0x20080005, PCWre = 1, PCSrc = 0, jump = 0 -> imem_addr = 0 in REQ; next cycle instr_valid = 1, op = 6'h08, rt = 8; then pc = 4 and REQ at address 4.
- Branch: pc = 0x10, imm_ext = 0xFFFF_FFFE, PCSrc = 1 -> next pc = 0x14 - 8 = 0x0C.
- Branch: pc = 0x10, imm_ext = 3, PCSrc = 1, jump = 1 -> jump wins; instr[25:0] = 0x40 gives next pc = 0x100.
- Wait and watchdog:
  - Memory ready after 3 wait cycles -> imem_addr stable, imem_req held high for 4 cycles, then a single instr_valid.
  - MAX_WAIT = 4 with no ready -> fetch_err = 1 after 4 WAIT cycles; halted = 0; imem_req = 0 thereafter.
- Halt instruction (PCWre = 0) at pc = 0x20 -> halted = 1, pc stays 0x20, no further imem_req across 20 cycles.
- Wrap and mid-wait reset:
  - pc = 0xFFFF_FFFC sequential -> pc = 0.
  - rst_n pulsed low mid-WAIT -> imem_req drops immediately; op = 0, funct = 0; refetch from RESET_PC after release.

Source files
------------

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the single-cycle CPU front end.
//   - fetch_state_t : 2-bit fetch FSM encoding (REQ, WAIT, EXEC, HALT)
//   - instruction field bit positions (op, rs, rt, rd, funct, jump address)
//   - DEF_RESET_PC  : default reset program counter
// No ports (package).
// -----------------------------------------------------------------------------
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_EXEC = 2'd2,
    ST_HALT = 2'd3
  } fetch_state_t;

  localparam int OP_HI    = 31;
  localparam int OP_LO    = 26;
  localparam int RS_HI    = 25;
  localparam int RS_LO    = 21;
  localparam int RT_HI    = 20;
  localparam int RT_LO    = 16;
  localparam int RD_HI    = 15;
  localparam int RD_LO    = 11;
  localparam int FUNCT_HI = 5;
  localparam int FUNCT_LO = 0;
  localparam int JADDR_HI = 25;
  localparam int JADDR_LO = 0;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

endpackage : cpu_pkg

// File: rtl/next_pc_calc.sv
// -----------------------------------------------------------------------------
// next_pc_calc
// Combinational next-PC selection: sequential, branch and jump targets.
// Priority: jump > branch (PCSrc) > sequential. All sums wrap modulo 2^32.
// Ports:
//   i_pc        in  32  address of the current instruction
//   i_instr     in  32  current instruction (jump target field used)
//   i_imm_ext   in  32  extended immediate (branch word offset)
//   i_pcsrc     in  1   take branch
//   i_jump      in  1   take jump
//   o_pc_plus4  out 32  i_pc + 4
//   o_next_pc   out 32  selected next PC
// -----------------------------------------------------------------------------
module next_pc_calc
  import cpu_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_imm_ext,
  input  logic        i_pcsrc,
  input  logic        i_jump,
  output logic [31:0] o_pc_plus4,
  output logic [31:0] o_next_pc
);

  logic        [31:0] w_pc_plus4;
  logic signed [31:0] w_imm_s;
  logic signed [31:0] w_br_off;
  logic        [31:0] w_br_tgt;
  logic        [31:0] w_j_tgt;

  assign w_pc_plus4 = i_pc + 32'd4;

  // Immediate is a signed word offset; scale to bytes.
  assign w_imm_s  = i_imm_ext;
  assign w_br_off = w_imm_s <<< 2;
  assign w_br_tgt = w_pc_plus4 + $unsigned(w_br_off);

  // Jump stays inside the 256 MB region of the sequential successor.
  assign w_j_tgt  = {w_pc_plus4[31:28], i_instr[JADDR_HI:JADDR_LO], 2'b00};

  always_comb begin
    o_next_pc = w_pc_plus4;
    if (i_jump) begin
      o_next_pc = w_j_tgt;
    end else if (i_pcsrc) begin
      o_next_pc = w_br_tgt;
    end
  end

  assign o_pc_plus4 = w_pc_plus4;

endmodule : next_pc_calc

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// Fetch stage: holds the PC, fetches one word per instruction over a
// req/ready handshake, presents it for a single execute cycle, then
// advances the PC from the control unit's PCWre/PCSrc/jump decision.
// A watchdog bounds the time spent waiting on memory; a halt instruction
// (PCWre = 0) parks the stage until reset.
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   PCWre, PCSrc, jump       control: advance / branch / jump
//   imm_ext      in  32      extended immediate
//   imem_req     out 1       fetch request (REQ/WAIT)
//   imem_addr    out 32      word-aligned fetch address (= pc)
//   imem_ready   in  1       memory data valid this cycle
//   imem_rdata   in  32      instruction word
//   instr        out 32      instruction register
//   instr_valid  out 1       execute-cycle strobe
//   op, funct    out 6       instruction fields
//   rs, rt, rd   out 5       register fields
//   pc, pc_plus4 out 32      current PC and PC + 4
//   halted       out 1       stopped by halt instruction
//   fetch_err    out 1       watchdog expired (sticky)
// -----------------------------------------------------------------------------
module instr_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter int unsigned MAX_WAIT = 16,
  parameter int unsigned CNT_W    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PCWre,
  input  logic        PCSrc,
  input  logic        jump,
  input  logic [31:0] imm_ext,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [5:0]  op,
  output logic [5:0]  funct,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        halted,
  output logic        fetch_err
);

  localparam logic [31:0]      PC_INIT  = {RESET_PC[31:2], 2'b00};
  localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(MAX_WAIT);

  fetch_state_t     r_state;
  fetch_state_t     w_state_nxt;
  logic [31:0]      r_pc;
  logic [31:0]      r_instr;
  logic [CNT_W-1:0] r_cnt;
  logic             r_halted;
  logic             r_fetch_err;

  logic [31:0]      w_next_pc;
  logic [31:0]      w_pc_plus4;
  logic [CNT_W-1:0] w_cnt_plus1;
  logic             w_req;
  logic             w_valid;
  logic             w_ld_instr;
  logic             w_ld_pc;
  logic             w_cnt_clr;
  logic             w_cnt_inc;
  logic             w_set_halt;
  logic             w_set_err;

  next_pc_calc u_next_pc (
    .i_pc       (r_pc),
    .i_instr    (r_instr),
    .i_imm_ext  (imm_ext),
    .i_pcsrc    (PCSrc),
    .i_jump     (jump),
    .o_pc_plus4 (w_pc_plus4),
    .o_next_pc  (w_next_pc)
  );

  assign w_cnt_plus1 = r_cnt + CNT_W'(1);

  // ---- FSM: state register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_REQ;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---- FSM: next state and per-state actions ----
  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    w_valid     = 1'b0;
    w_ld_instr  = 1'b0;
    w_ld_pc     = 1'b0;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
    w_set_halt  = 1'b0;
    w_set_err   = 1'b0;
    unique case (r_state)
      ST_REQ: begin
        w_req = 1'b1;
        if (imem_ready) begin
          w_ld_instr  = 1'b1;
          w_state_nxt = ST_EXEC;
        end else begin
          w_cnt_clr   = 1'b1;
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        w_req = 1'b1;
        if (imem_ready) begin
          w_ld_instr  = 1'b1;
          w_state_nxt = ST_EXEC;
        end else begin
          w_cnt_inc = 1'b1;
          // Incremented count equals the number of WAIT cycles spent so far.
          if ((MAX_WAIT != 0) && (w_cnt_plus1 == WAIT_LIM)) begin
            w_set_err   = 1'b1;
            w_state_nxt = ST_HALT;
          end
        end
      end
      ST_EXEC: begin
        w_valid = 1'b1;
        if (PCWre) begin
          w_ld_pc     = 1'b1;
          w_state_nxt = ST_REQ;
        end else begin
          w_set_halt  = 1'b1;
          w_state_nxt = ST_HALT;
        end
      end
      ST_HALT: begin
        w_state_nxt = ST_HALT;
      end
      default: begin
        w_state_nxt = ST_REQ;
      end
    endcase
  end

  // ---- Datapath and status registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc        <= PC_INIT;
      r_instr     <= '0;
      r_cnt       <= '0;
      r_halted    <= 1'b0;
      r_fetch_err <= 1'b0;
    end else begin
      if (w_ld_pc) begin
        r_pc <= w_next_pc;
      end
      if (w_ld_instr) begin
        r_instr <= imem_rdata;
      end
      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if (w_cnt_inc) begin
        r_cnt <= w_cnt_plus1;
      end
      if (w_set_halt) begin
        r_halted <= 1'b1;
      end
      if (w_set_err) begin
        r_fetch_err <= 1'b1;
      end
    end
  end

  // ---- Outputs ----
  // The state register resets to REQ, so the request is also gated by
  // rst_n to keep the bus quiet for the whole time reset is held.
  assign imem_req    = w_req & rst_n;
  assign instr_valid = w_valid & rst_n;
  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign pc_plus4    = w_pc_plus4;
  assign instr       = r_instr;
  assign op          = r_instr[OP_HI:OP_LO];
  assign funct       = r_instr[FUNCT_HI:FUNCT_LO];
  assign rs          = r_instr[RS_HI:RS_LO];
  assign rt          = r_instr[RT_HI:RT_LO];
  assign rd          = r_instr[RD_HI:RD_LO];
  assign halted      = r_halted;
  assign fetch_err   = r_fetch_err;

endmodule : instr_fetch
